// File: rtl/trace_pkg.sv
// ============================================================================
// Module  : trace_pkg
// Brief   : Shared record types for the commit trace packer. Defining
//           COMMIT_TRACE_CYCLE_STAMP_EN adds a 64-bit stamp to each record.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package trace_pkg;

    localparam int SEQ_W = 16;

    typedef enum logic [0:0] {
        COMMIT    = 1'b0,
        EXCEPTION = 1'b1
    } rec_kind_t;

    typedef struct packed {
        rec_kind_t          kind;
        logic [63:0]        pc;
        logic [31:0]        instr;
        logic [4:0]         rd;
        logic               we;
        logic [63:0]        data;
        logic [63:0]        tval;
        logic [1:0]         priv;
        logic [SEQ_W-1:0]   seq;
        logic               lost;
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
        logic [63:0]        stamp;
`endif
    } trace_rec_t;

endpackage

`default_nettype wire

// File: rtl/commit_trace_packer_if.sv
// ============================================================================
// Module  : commit_trace_packer_if
// Brief   : Commit/exception inputs and record output handshake of the packer.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface commit_trace_packer_if
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) ();

    localparam int c_lvl_w = $clog2(DEPTH) + 1;

    logic [1:0]         commit_ack_i;
    logic [1:0][63:0]   commit_pc_i;
    logic [1:0][31:0]   commit_instr_i;
    logic [1:0]         we_i;
    logic [1:0][4:0]    waddr_i;
    logic [1:0][63:0]   wdata_i;
    logic [1:0]         priv_lvl_i;
    logic               ex_valid_i;
    logic [63:0]        ex_pc_i;
    logic [63:0]        ex_cause_i;
    logic [63:0]        ex_tval_i;
    logic               rec_valid_o;
    logic               rec_ready_i;
    trace_rec_t         rec_o;
    logic [31:0]        drop_cnt_o;
    logic [c_lvl_w-1:0] level_o;

    modport master (
        output commit_ack_i, commit_pc_i, commit_instr_i, we_i, waddr_i, wdata_i,
        output priv_lvl_i, ex_valid_i, ex_pc_i, ex_cause_i, ex_tval_i, rec_ready_i,
        input  rec_valid_o, rec_o, drop_cnt_o, level_o
    );

    modport slave (
        input  commit_ack_i, commit_pc_i, commit_instr_i, we_i, waddr_i, wdata_i,
        input  priv_lvl_i, ex_valid_i, ex_pc_i, ex_cause_i, ex_tval_i, rec_ready_i,
        output rec_valid_o, rec_o, drop_cnt_o, level_o
    );

endinterface

`default_nettype wire

// File: rtl/trace_fifo_mw.sv
// ============================================================================
// Module  : trace_fifo_mw
// Brief   : Record FIFO taking up to three writes and one read per cycle.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_fifo_mw
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  wire                            clk,
    input  wire                            rst,
    input  wire  [1:0]                     i_wr_cnt,
    input  var   trace_rec_t [2:0]         i_wr_data,
    input  wire                            i_rd_en,
    output trace_rec_t                     o_rd_data,
    output logic [$clog2(DEPTH):0]         o_level
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_lvl_w  = c_addr_w + 1;

    trace_rec_t          r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wptr;
    logic [c_addr_w-1:0] r_rptr;
    logic [c_lvl_w-1:0]  r_level;

    // Entries are written in list order from the write pointer; the address
    // width makes a multi-write wrap around the end of storage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                if (k < int'(i_wr_cnt)) begin
                    r_mem[r_wptr + c_addr_w'(k)] <= i_wr_data[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            r_wptr  <= r_wptr + c_addr_w'(i_wr_cnt);
            r_rptr  <= r_rptr + c_addr_w'(i_rd_en);
            r_level <= r_level + c_lvl_w'(i_wr_cnt) - c_lvl_w'(i_rd_en);
        end
    end

    // Storage is not reset, so an empty FIFO presents an all-zero record.
    assign o_rd_data = (r_level != '0) ? r_mem[r_rptr] : '0;
    assign o_level   = r_level;

endmodule

`default_nettype wire

// File: rtl/commit_trace_packer.sv
// ============================================================================
// Module  : commit_trace_packer
// Brief   : Packs dual-port commits and exceptions into an ordered trace record
//           stream; COMMIT_TRACE_CYCLE_STAMP_EN adds a push-cycle stamp.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_trace_packer
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  wire                    clk_i,
    input  wire                    rst_i,
    commit_trace_packer_if.slave   bus
);

    localparam int c_lvl_w = $clog2(DEPTH) + 1;

    logic [c_lvl_w-1:0] w_level;
    logic [c_lvl_w-1:0] w_free;
    logic [1:0]         w_push_cnt;
    logic [1:0]         w_wr_cnt;
    logic               w_accept;
    logic               w_valid;
    logic               w_pop;
    logic [SEQ_W-1:0]   r_seq;
    logic [SEQ_W-1:0]   w_seq_c1;
    logic [SEQ_W-1:0]   w_seq_ex;
    logic               r_lost;
    logic [31:0]        r_drop_cnt;
    trace_rec_t         w_rec_c0;
    trace_rec_t         w_rec_c1;
    trace_rec_t         w_rec_ex;
    trace_rec_t         w_rd_data;
    trace_rec_t [2:0]   w_slot;
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
    logic [63:0]        r_cycle;
`endif

    assign w_push_cnt = 2'(bus.commit_ack_i[0]) + 2'(bus.commit_ack_i[1])
                      + 2'(bus.ex_valid_i);
    // Free space is taken before this cycle's pop: a pop gives no credit.
    assign w_free     = c_lvl_w'(DEPTH) - w_level;
    assign w_accept   = c_lvl_w'(w_push_cnt) <= w_free;
    assign w_wr_cnt   = w_accept ? w_push_cnt : 2'd0;
    assign w_valid    = (w_level != '0);
    assign w_pop      = w_valid & bus.rec_ready_i;

    // Exceptions share the sequence number of the next commit.
    assign w_seq_c1   = r_seq + SEQ_W'(bus.commit_ack_i[0]);
    assign w_seq_ex   = w_seq_c1 + SEQ_W'(bus.commit_ack_i[1]);

    always_comb begin
        w_rec_c0       = '0;
        w_rec_c0.kind  = COMMIT;
        w_rec_c0.pc    = bus.commit_pc_i[0];
        w_rec_c0.instr = bus.commit_instr_i[0];
        w_rec_c0.rd    = bus.waddr_i[0];
        w_rec_c0.we    = bus.we_i[0];
        w_rec_c0.data  = bus.we_i[0] ? bus.wdata_i[0] : 64'd0;
        w_rec_c0.priv  = bus.priv_lvl_i;
        w_rec_c0.seq   = r_seq;

        w_rec_c1       = '0;
        w_rec_c1.kind  = COMMIT;
        w_rec_c1.pc    = bus.commit_pc_i[1];
        w_rec_c1.instr = bus.commit_instr_i[1];
        w_rec_c1.rd    = bus.waddr_i[1];
        w_rec_c1.we    = bus.we_i[1];
        w_rec_c1.data  = bus.we_i[1] ? bus.wdata_i[1] : 64'd0;
        w_rec_c1.priv  = bus.priv_lvl_i;
        w_rec_c1.seq   = w_seq_c1;

        w_rec_ex       = '0;
        w_rec_ex.kind  = EXCEPTION;
        w_rec_ex.pc    = bus.ex_pc_i;
        w_rec_ex.data  = bus.ex_cause_i;
        w_rec_ex.tval  = bus.ex_tval_i;
        w_rec_ex.priv  = bus.priv_lvl_i;
        w_rec_ex.seq   = w_seq_ex;

`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
        w_rec_c0.stamp = r_cycle;
        w_rec_c1.stamp = r_cycle;
        w_rec_ex.stamp = r_cycle;
`endif

        // Compact the present records into slots 0..w_push_cnt-1.
        w_slot[0] = bus.commit_ack_i[0] ? w_rec_c0 :
                    bus.commit_ack_i[1] ? w_rec_c1 : w_rec_ex;
        w_slot[1] = (&bus.commit_ack_i) ? w_rec_c1 : w_rec_ex;
        w_slot[2] = w_rec_ex;
        w_slot[0].lost = r_lost;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_seq      <= '0;
            r_lost     <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_accept) begin
            r_seq <= w_seq_ex;
            if (w_push_cnt != 2'd0) begin
                r_lost <= 1'b0;
            end
        end else begin
            r_lost <= 1'b1;
            if (r_drop_cnt != 32'hFFFF_FFFF) begin
                r_drop_cnt <= r_drop_cnt + 32'd1;
            end
        end
    end

`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
        end
    end
`endif

    trace_fifo_mw #(
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk_i),
        .rst        (rst_i),
        .i_wr_cnt   (w_wr_cnt),
        .i_wr_data  (w_slot),
        .i_rd_en    (w_pop),
        .o_rd_data  (w_rd_data),
        .o_level    (w_level)
    );

    assign bus.rec_valid_o = w_valid;
    assign bus.rec_o       = w_rd_data;
    assign bus.level_o     = w_level;
    assign bus.drop_cnt_o  = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_commit_trace_packer.sv
// ============================================================================
// Module  : tb_commit_trace_packer
// Brief   : Directed and random checks of commit_trace_packer against a
//           queue-based record model.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_commit_trace_packer;
    import trace_pkg::*;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    commit_trace_packer_if #(.DEPTH(DEPTH)) bus ();

    commit_trace_packer #(.DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int           checks = 0;
    int           errors = 0;
    trace_rec_t   m_q[$];
    int           m_seq  = 0;
    bit           m_lost = 1'b0;
    longint       m_drop = 0;
    longint       m_cyc  = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.commit_ack_i = 2'b00;
        bus.ex_valid_i   = 1'b0;
    endtask

    task automatic randomize_payload();
        for (int p = 0; p < 2; p++) begin
            bus.commit_pc_i[p]    = {$urandom, $urandom};
            bus.commit_instr_i[p] = $urandom;
            bus.we_i[p]           = 1'($urandom);
            bus.waddr_i[p]        = 5'($urandom);
            bus.wdata_i[p]        = {$urandom, $urandom};
        end
        bus.priv_lvl_i = 2'($urandom);
        bus.ex_pc_i    = {$urandom, $urandom};
        bus.ex_cause_i = {$urandom, $urandom};
        bus.ex_tval_i  = {$urandom, $urandom};
    endtask

    // One clock of the reference: gather this cycle's records, accept all or
    // none against start-of-cycle space, then retire the head if handshaken.
    task automatic model_step();
        trace_rec_t lst[$];
        trace_rec_t r;
        bit         pop;
        if (rst) begin
            m_q.delete();
            m_seq  = 0;
            m_lost = 1'b0;
            m_drop = 0;
            m_cyc  = 0;
            return;
        end
        pop = (m_q.size() != 0) && bus.rec_ready_i;
        for (int p = 0; p < 2; p++) begin
            if (bus.commit_ack_i[p]) begin
                r       = '0;
                r.kind  = COMMIT;
                r.pc    = bus.commit_pc_i[p];
                r.instr = bus.commit_instr_i[p];
                r.rd    = bus.waddr_i[p];
                r.we    = bus.we_i[p];
                r.data  = bus.we_i[p] ? bus.wdata_i[p] : 64'd0;
                r.priv  = bus.priv_lvl_i;
                lst.push_back(r);
            end
        end
        if (bus.ex_valid_i) begin
            r      = '0;
            r.kind = EXCEPTION;
            r.pc   = bus.ex_pc_i;
            r.data = bus.ex_cause_i;
            r.tval = bus.ex_tval_i;
            r.priv = bus.priv_lvl_i;
            lst.push_back(r);
        end
        if (lst.size() <= DEPTH - m_q.size()) begin
            for (int i = 0; i < lst.size(); i++) begin
                r      = lst[i];
                r.seq  = 16'(m_seq);
                r.lost = (i == 0) ? m_lost : 1'b0;
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
                r.stamp = 64'(m_cyc);
`endif
                if (r.kind == COMMIT) m_seq = (m_seq + 1) % 65536;
                m_q.push_back(r);
            end
            if (lst.size() != 0) m_lost = 1'b0;
        end else begin
            if (m_drop != 64'hFFFF_FFFF) m_drop++;
            m_lost = 1'b1;
        end
        if (pop) void'(m_q.pop_front());
        m_cyc++;
    endtask

    task automatic cycle();
        chk("rec_valid", 512'(bus.rec_valid_o), 512'(m_q.size() != 0));
        chk("level", 512'(bus.level_o), 512'(m_q.size()));
        chk("drop_cnt", 512'(bus.drop_cnt_o), 512'(m_drop));
        if (m_q.size() != 0) chk("head_rec", 512'(bus.rec_o), 512'(m_q[0]));
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        randomize_payload();
        bus.rec_ready_i = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_step();
        rst = 1'b0;

        // Reset state
        chk("rst_valid", 512'(bus.rec_valid_o), 512'(0));
        chk("rst_level", 512'(bus.level_o), 512'(0));
        chk("rst_drop", 512'(bus.drop_cnt_o), 512'(0));
        chk("rst_rec", 512'(bus.rec_o), 512'(0));

        // Two acked ports into an empty FIFO
        bus.commit_ack_i   = 2'b11;
        bus.commit_pc_i[0] = 64'h8000_0000;
        bus.commit_pc_i[1] = 64'h8000_0004;
        cycle();
        idle();
        chk("dual_level", 512'(bus.level_o), 512'(2));
        chk("dual_pc0", 512'(bus.rec_o.pc), 512'(64'h8000_0000));
        chk("dual_seq0", 512'(bus.rec_o.seq), 512'(0));
        bus.rec_ready_i = 1'b1;
        cycle();
        chk("dual_pc1", 512'(bus.rec_o.pc), 512'(64'h8000_0004));
        chk("dual_seq1", 512'(bus.rec_o.seq), 512'(1));
        cycle();

        // Three pushes at level 6 are dropped together
        bus.rec_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            randomize_payload();
            bus.commit_ack_i = 2'b11;
            cycle();
        end
        chk("fill6_level", 512'(bus.level_o), 512'(6));
        bus.ex_valid_i = 1'b1;
        cycle();
        idle();
        chk("drop3_level", 512'(bus.level_o), 512'(6));
        chk("drop3_cnt", 512'(bus.drop_cnt_o), 512'(1));
        randomize_payload();
        bus.commit_ack_i = 2'b01;
        cycle();
        idle();
        bus.rec_ready_i = 1'b1;
        repeat (6) cycle();
        chk("lost_flag", 512'(bus.rec_o.lost), 512'(1));
        chk("lost_seq", 512'(bus.rec_o.seq), 512'(8));
        cycle();

        // Commit plus exception in one cycle, then one more commit
        bus.rec_ready_i  = 1'b0;
        randomize_payload();
        bus.commit_ack_i = 2'b01;
        bus.ex_valid_i   = 1'b1;
        bus.ex_cause_i   = 64'd2;
        bus.ex_tval_i    = 64'hdead;
        cycle();
        idle();
        randomize_payload();
        bus.commit_ack_i = 2'b01;
        cycle();
        idle();
        chk("cx_kind0", 512'(bus.rec_o.kind), 512'(COMMIT));
        chk("cx_seq0", 512'(bus.rec_o.seq), 512'(9));
        bus.rec_ready_i = 1'b1;
        cycle();
        chk("cx_kind1", 512'(bus.rec_o.kind), 512'(EXCEPTION));
        chk("cx_cause", 512'(bus.rec_o.data), 512'(2));
        chk("cx_tval", 512'(bus.rec_o.tval), 512'(64'hdead));
        chk("cx_seq1", 512'(bus.rec_o.seq), 512'(10));
        cycle();
        chk("cx_seq2", 512'(bus.rec_o.seq), 512'(10));
        cycle();

        // Full FIFO: a same-cycle pop gives no room for a push
        bus.rec_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            randomize_payload();
            bus.commit_ack_i = 2'b11;
            cycle();
        end
        idle();
        chk("full_level", 512'(bus.level_o), 512'(8));
        bus.rec_ready_i  = 1'b1;
        bus.commit_ack_i = 2'b01;
        cycle();
        idle();
        bus.rec_ready_i = 1'b0;
        chk("full_pop_level", 512'(bus.level_o), 512'(7));
        chk("full_drop_cnt", 512'(bus.drop_cnt_o), 512'(2));
        bus.rec_ready_i = 1'b1;
        repeat (8) cycle();

        // Mid-operation reset with five records queued
        bus.rec_ready_i = 1'b0;
        bus.commit_ack_i = 2'b11;
        cycle();
        cycle();
        bus.commit_ack_i = 2'b01;
        cycle();
        chk("pre_rst_level", 512'(bus.level_o), 512'(5));
        bus.commit_ack_i = 2'b11;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        idle();
        chk("mid_rst_valid", 512'(bus.rec_valid_o), 512'(0));
        chk("mid_rst_level", 512'(bus.level_o), 512'(0));
        chk("mid_rst_drop", 512'(bus.drop_cnt_o), 512'(0));

        // Random traffic, first congested then mostly draining
        for (int i = 0; i < 2000; i++) begin
            randomize_payload();
            bus.commit_ack_i = 2'($urandom);
            bus.ex_valid_i   = ($urandom_range(0, 3) == 0);
            bus.rec_ready_i  = ($urandom_range(0, 99) < ((i < 1000) ? 40 : 80));
            rst              = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 1'b0;
        idle();
        bus.rec_ready_i = 1'b1;
        repeat (DEPTH + 1) cycle();

        // Sequence wrap after 65536 accepted commits
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            bus.commit_pc_i[0] = {$urandom, $urandom};
            bus.commit_ack_i   = 2'b01;
            cycle();
        end
        chk("wrap_ffff", 512'(bus.rec_o.seq), 512'(16'hFFFF));
        cycle();
        idle();
        chk("wrap_zero", 512'(bus.rec_o.seq), 512'(0));
        chk("wrap_kind", 512'(bus.rec_o.kind), 512'(COMMIT));
        repeat (2) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
